// File: rtl/wb_bus_pkg.sv
// Shared definitions for the shared-bus Wishbone controller family.
// Holds master count, grant width, default watchdog limit and FSM encoding.
package wb_bus_pkg;

    localparam int unsigned NumMasters = 4;
    localparam int unsigned GntW       = 2;
    localparam int unsigned DefTimeout = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOwn   = 2'd1,
        StAbort = 2'd2
    } bus_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping,
// and returns the first requesting master.
module wb_rr_pick
    import wb_bus_pkg::*;
(
    input  logic [NumMasters-1:0] req_i,
    input  logic [GntW-1:0]       last_i,
    output logic [GntW-1:0]       win_o,
    output logic                  valid_o
);

    logic [GntW-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        win_o   = last_i;
        valid_o = 1'b0;
        idx     = last_i;
        for (int i = NumMasters; i >= 1; i--) begin
            idx = last_i + GntW'(i);
            if (req_i[idx]) begin
                win_o   = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_shared_bus_ctl.sv
// Four-master shared-bus Wishbone controller: locked round-robin ownership,
// strobe gating, termination routing and a stall watchdog that aborts with ERR.
module wb_shared_bus_ctl
    import wb_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefTimeout,
    parameter int unsigned TW      = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NumMasters-1:0] CYC_I,
    input  logic [NumMasters-1:0] STB_I,
    input  logic                  ACK_S,
    input  logic                  ERR_S,
    input  logic                  RTY_S,
    output logic                  CYC_O,
    output logic                  STB_O,
    output logic [GntW-1:0]       GNT,
    output logic [NumMasters-1:0] GNT_V,
    output logic [NumMasters-1:0] ACK_O,
    output logic [NumMasters-1:0] ERR_O,
    output logic [NumMasters-1:0] RTY_O,
    output logic                  BUSY,
    output logic                  TOUT
);

    bus_state_e            state_q;
    logic [GntW-1:0]       gnt_q;
    logic [NumMasters-1:0] gnt_v_q;
    logic [GntW-1:0]       last_q;
    logic [TW-1:0]         wd_q;
    logic                  tout_q;

    logic [GntW-1:0] pick_win;
    logic            pick_valid;
    logic            cyc_own;
    logic            stb_own;
    logic            term;
    logic            stall;

    wb_rr_pick u_pick (
        .req_i   (CYC_I),
        .last_i  (last_q),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    assign cyc_own = CYC_I[gnt_q];
    assign stb_own = STB_I[gnt_q];
    assign term    = ACK_S | ERR_S | RTY_S;
    assign stall   = (state_q == StOwn) & stb_own & ~term;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            gnt_v_q <= '0;
            last_q  <= GntW'(NumMasters - 1);
            wd_q    <= '0;
            tout_q  <= 1'b0;
        end else begin
            tout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    gnt_v_q <= '0;
                    wd_q    <= '0;
                    if (pick_valid) begin
                        gnt_q   <= pick_win;
                        gnt_v_q <= NumMasters'(1) << pick_win;
                        state_q <= StOwn;
                    end
                end
                StOwn: begin
                    // Abort wins over a same-cycle release.
                    if (stall && (wd_q == TW'(TIMEOUT - 1))) begin
                        state_q <= StAbort;
                        tout_q  <= 1'b1;
                        wd_q    <= '0;
                    end else if (!cyc_own) begin
                        state_q <= StIdle;
                        last_q  <= gnt_q;
                        gnt_v_q <= '0;
                        wd_q    <= '0;
                    end else if (stall) begin
                        wd_q <= wd_q + 1'b1;
                    end else begin
                        wd_q <= '0;
                    end
                end
                StAbort: begin
                    if (!cyc_own) begin
                        state_q <= StIdle;
                        last_q  <= gnt_q;
                        gnt_v_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Slave responses reach only the owner, and only while its strobe is up.
    always_comb begin
        CYC_O = 1'b0;
        STB_O = 1'b0;
        ACK_O = '0;
        ERR_O = '0;
        RTY_O = '0;
        if (state_q == StOwn) begin
            CYC_O = cyc_own;
            STB_O = stb_own;
            if (stb_own) begin
                ACK_O[gnt_q] = ACK_S;
                ERR_O[gnt_q] = ERR_S;
                RTY_O[gnt_q] = RTY_S;
            end
        end else if (state_q == StAbort) begin
            CYC_O        = cyc_own;
            ERR_O[gnt_q] = tout_q;
        end
    end

    assign GNT   = gnt_q;
    assign GNT_V = gnt_v_q;
    assign BUSY  = (state_q != StIdle);
    assign TOUT  = tout_q;

endmodule

// File: tb/tb_wb_shared_bus_ctl.sv
// Directed bench for wb_shared_bus_ctl; expected grant owners are queued as
// requests are raised and popped when a grant appears.
module tb_wb_shared_bus_ctl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] CYC_I, STB_I;
    logic       ACK_S, ERR_S, RTY_S;
    logic       CYC_O, STB_O;
    logic [1:0] GNT;
    logic [3:0] GNT_V, ACK_O, ERR_O, RTY_O;
    logic       BUSY, TOUT;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    always #5 CLK = ~CLK;

    wb_shared_bus_ctl #(
        .TIMEOUT (16),
        .TW      (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CYC_I (CYC_I),
        .STB_I (STB_I),
        .ACK_S (ACK_S),
        .ERR_S (ERR_S),
        .RTY_S (RTY_S),
        .CYC_O (CYC_O),
        .STB_O (STB_O),
        .GNT   (GNT),
        .GNT_V (GNT_V),
        .ACK_O (ACK_O),
        .ERR_O (ERR_O),
        .RTY_O (RTY_O),
        .BUSY  (BUSY),
        .TOUT  (TOUT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a grant, counting idle cycles, then checks the queued owner.
    task automatic await_grant(input string tag, input int exp_gap);
        int gap = 0;
        int owner;
        while (GNT_V == 4'b0 && gap < 20) begin
            chk({tag, "_idle_cyc"}, {31'b0, CYC_O}, 32'd0);
            gap++;
            tick();
        end
        owner = exp_q.pop_front();
        chk({tag, "_gap"}, gap, exp_gap);
        chk({tag, "_gnt"}, {30'b0, GNT}, owner);
        chk({tag, "_gntv"}, {28'b0, GNT_V}, 32'd1 << owner);
        chk({tag, "_busy"}, {31'b0, BUSY}, 32'd1);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        CYC_I = '0;
        STB_I = '0;
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        RST_N = 1'b0;
        CYC_I = '0;
        STB_I = '0;
        ACK_S = 1'b0;
        ERR_S = 1'b0;
        RTY_S = 1'b0;
        tick();
        tick();
        chk("rst_gnt", {30'b0, GNT}, 32'd0);
        chk("rst_gntv", {28'b0, GNT_V}, 32'd0);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_cyc_stb", {30'b0, CYC_O, STB_O}, 32'd0);
        chk("rst_tout", {31'b0, TOUT}, 32'd0);
        chk("rst_resp", {20'b0, ACK_O, ERR_O, RTY_O}, 32'd0);
        RST_N = 1'b1;

        // Two requesters together: master 0 first, then master 2 after one idle cycle.
        tick();
        CYC_I = 4'b0101;
        STB_I = 4'b0101;
        #1;
        exp_q.push_back(0);
        await_grant("t1", 1);
        chk("t1_cyc_stb", {30'b0, CYC_O, STB_O}, 32'd3);
        ACK_S = 1'b1;
        #1;
        chk("t1_ack", {28'b0, ACK_O}, 32'h1);
        chk("t1_err", {28'b0, ERR_O}, 32'h0);
        tick();
        ACK_S = 1'b0;
        CYC_I = 4'b0100;
        STB_I = 4'b0100;
        #1;
        chk("t1_drop_cyc", {31'b0, CYC_O}, 32'd0);
        tick();
        chk("t1_idle_gnt_hold", {30'b0, GNT}, 32'd0);
        exp_q.push_back(2);
        await_grant("t1b", 1);
        CYC_I = '0;
        STB_I = '0;
        tick();

        // All four requesting: rotation 0,1,2,3,0 with one idle cycle between owners.
        do_reset();
        CYC_I = 4'hF;
        STB_I = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(k % 4);
            await_grant("t2", 1);
            ACK_S = 1'b1;
            #1;
            chk("t2_ack", {28'b0, ACK_O}, 32'd1 << (k % 4));
            tick();
            ACK_S = 1'b0;
            if (k == 4) begin
                CYC_I = '0;
                STB_I = '0;
            end else begin
                CYC_I[k % 4] = 1'b0;
                STB_I[k % 4] = 1'b0;
            end
            #1;
            tick();
            chk("t2_release_idle", {31'b0, BUSY}, 32'd0);
            if (k < 4) begin
                CYC_I[k % 4] = 1'b1;
                STB_I[k % 4] = 1'b1;
            end
            #1;
        end

        // Owner 1 holds through 10 beats while master 3 waits.
        CYC_I = 4'b1010;
        STB_I = 4'b0010;
        #1;
        exp_q.push_back(1);
        await_grant("t3", 1);
        for (int b = 0; b < 10; b++) begin
            ACK_S = 1'b1;
            #1;
            chk("t3_hold_gnt", {28'b0, GNT_V}, 32'h2);
            chk("t3_ack", {28'b0, ACK_O}, 32'h2);
            tick();
        end
        ACK_S = 1'b0;
        CYC_I[1] = 1'b0;
        STB_I[1] = 1'b0;
        #1;
        tick();
        exp_q.push_back(3);
        await_grant("t3b", 1);
        CYC_I = '0;
        tick();

        // Stalled owner 2: abort after 16 strobe cycles, one-cycle ERR/TOUT.
        CYC_I = 4'b0100;
        STB_I = 4'b0100;
        #1;
        exp_q.push_back(2);
        await_grant("t4", 1);
        for (int i = 0; i < 16; i++) begin
            chk("t4_stall_tout", {31'b0, TOUT}, 32'd0);
            chk("t4_stall_stb", {31'b0, STB_O}, 32'd1);
            tick();
        end
        chk("t4_tout", {31'b0, TOUT}, 32'd1);
        chk("t4_err", {28'b0, ERR_O}, 32'h4);
        chk("t4_abort_cyc_stb", {30'b0, CYC_O, STB_O}, 32'd2);
        ACK_S = 1'b1;
        #1;
        chk("t4_late_ack", {28'b0, ACK_O}, 32'h0);
        tick();
        chk("t4_tout_pulse", {31'b0, TOUT}, 32'd0);
        chk("t4_err_pulse", {28'b0, ERR_O}, 32'h0);
        chk("t4_abort_busy", {31'b0, BUSY}, 32'd1);
        ACK_S = 1'b0;
        CYC_I = '0;
        STB_I = '0;
        tick();
        chk("t4_to_idle", {31'b0, BUSY}, 32'd0);

        // Responses with strobe low are dropped and do not feed the watchdog.
        ACK_S = 1'b1;
        ERR_S = 1'b1;
        RTY_S = 1'b1;
        #1;
        chk("t6_idle_resp", {20'b0, ACK_O, ERR_O, RTY_O}, 32'd0);
        CYC_I = 4'b0001;
        #1;
        exp_q.push_back(0);
        await_grant("t6", 1);
        for (int i = 0; i < 20; i++) begin
            ACK_S = i[0];
            ERR_S = i[1];
            RTY_S = 1'b1;
            #1;
            chk("t6_stb_low_resp", {20'b0, ACK_O, ERR_O, RTY_O}, 32'd0);
            chk("t6_stb_low_tout", {31'b0, TOUT}, 32'd0);
            tick();
        end
        ACK_S = 1'b0;
        ERR_S = 1'b0;
        RTY_S = 1'b0;
        for (int i = 0; i < 21; i++) begin
            STB_I[0] = (i != 10);
            #1;
            chk("t6_wd_clear_tout", {31'b0, TOUT}, 32'd0);
            tick();
        end
        STB_I[0] = 1'b1;
        RTY_S = 1'b1;
        #1;
        chk("t6_rty", {28'b0, RTY_O}, 32'h1);
        chk("t6_busy", {31'b0, BUSY}, 32'd1);
        tick();
        RTY_S = 1'b0;
        CYC_I = '0;
        STB_I = '0;
        tick();

        // Asynchronous reset mid-ownership, then master 0 wins from reset pointer.
        CYC_I = 4'b0010;
        STB_I = 4'b0010;
        #1;
        exp_q.push_back(1);
        await_grant("t5", 1);
        #3;
        RST_N = 1'b0;
        #1;
        chk("t5_async_gntv", {28'b0, GNT_V}, 32'h0);
        chk("t5_async_cyc", {31'b0, CYC_O}, 32'd0);
        chk("t5_async_busy", {31'b0, BUSY}, 32'd0);
        CYC_I = 4'hF;
        STB_I = 4'hF;
        #2;
        RST_N = 1'b1;
        exp_q.push_back(0);
        await_grant("t5b", 1);
        CYC_I = '0;
        STB_I = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_shared_bus_ctl.md
Name: wb_shared_bus_ctl

Overview:
Four-master, shared-bus Wishbone controller with round-robin arbitration.
- Grants the bus to one master and holds the grant for that master's whole CYC cycle (locked ownership; no per-clock re-arbitration).
- Gates the granted master's STB onto the slave side and routes slave terminations back to that master only.
- Runs a watchdog that aborts stalled cycles with ERR.
- Sits between the master ports and the slave address decoder; the datapath mux uses GNT as its select.

Parameters:
TIMEOUT, 16, cycles of STB_O high with no ACK/ERR/RTY before abort (legal range 2..255)
TW, 8, watchdog counter width; must satisfy 2**TW > TIMEOUT

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
CYC_I  in  4  master cycle requests, bit n = master n
STB_I  in  4  master strobes
ACK_S  in  1  slave acknowledge
ERR_S  in  1  slave error
RTY_S  in  1  slave retry
CYC_O  out  1  shared-bus CYC
STB_O  out  1  shared-bus STB
GNT  out  2  encoded owner; datapath mux select
GNT_V  out  4  one-hot owner; all zero when no owner
ACK_O  out  4  per-master ACK
ERR_O  out  4  per-master ERR (slave error or timeout)
RTY_O  out  4  per-master RTY
BUSY  out  1  high in OWN or ABORT
TOUT  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Single clock domain. One clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset values: state IDLE, GNT=0, GNT_V=0, last-owner pointer=3 (so master 0 wins first), watchdog=0, CYC_O=STB_O=BUSY=TOUT=0, ACK_O=ERR_O=RTY_O=0.
- Reset asserted mid-cycle aborts the cycle immediately. No termination is issued to the master.
- FSM states: IDLE, OWN, ABORT.
- IDLE:
  - If any CYC_I bit is set, pick the winner round-robin. Search order starts at last+1 and wraps modulo 4.
  - Register the winner into GNT/GNT_V and go to OWN.
  - Request-to-grant latency is 1 clock.
  - If no CYC_I bit is set, stay in IDLE, GNT holds its last value and GNT_V=0.
- OWN:
  - CYC_O = CYC_I[GNT]; STB_O = STB_I[GNT]. Both combinational.
  - ACK_O[GNT]=ACK_S, ERR_O[GNT]=ERR_S, RTY_O[GNT]=RTY_S. These are qualified by STB_O. All other bits are 0.
  - Slave responses while STB_O=0 are dropped.
  - Watchdog behaviour:
    - Increments on each cycle with STB_O=1 and no ACK_S/ERR_S/RTY_S.
    - Clears on any termination and whenever STB_O=0.
  - Exit on timeout: the watchdog reaching TIMEOUT-1 while still unterminated → ABORT. The abort takes priority over a same-cycle CYC drop.
  - Exit on release: CYC_I[GNT]=0 → IDLE, and last=GNT.
  - Requests from other masters never preempt the owner.
- ABORT:
  - STB_O forced 0; CYC_O = CYC_I[GNT].
  - ERR_O[GNT]=1 and TOUT=1 for the first ABORT cycle only.
  - Late slave responses are ignored.
  - Stays in ABORT until CYC_I[GNT]=0, then → IDLE with last=GNT.
- Handoff: at least one IDLE cycle (CYC_O=0) separates consecutive owners.
  - Back-to-back cycles from the same master also pass through IDLE.
  - Round-robin then favours the other requesters.
- Simultaneous requests resolve strictly by the rotation order. A master requesting continuously waits at most 3 ownerships.
- Simultaneous ACK_S and ERR_S: both are passed through; the slave is responsible for not doing this.
- A single cycle with CYC_I[GNT]=1 and STB_I[GNT]=0 is legal (master idle inside its cycle). The watchdog does not count it.

Decomposition:
- Shared package wb_bus_pkg holds:
  - state encoding constants for IDLE/OWN/ABORT;
  - the number of masters (4) and the grant width (2);
  - the default TIMEOUT.
- Natural sub-module: wb_rr_pick. It is combinational; inputs are the 4-bit request and the 2-bit last pointer; outputs are the winner index and a valid flag. The same picker is reused by later N-master variants.
- The FSM, watchdog and response routing stay in wb_shared_bus_ctl.

Test Plan:
- Reset, then CYC_I=4'b0101 raised together → next clock GNT=0, GNT_V=0001, BUSY=1. ACK_S on the STB cycle → ACK_O=0001 only. Master 0 drops CYC → 1 IDLE cycle, then GNT=2.
- All four CYC_I held high, each master dropping CYC after one ACK → grant order 0,1,2,3,0 with exactly one CYC_O=0 cycle between owners.
- Owner 1 holds CYC for 10 ACKed beats while master 3 requests → GNT stays 1 throughout. GNT=3 appears 2 clocks after CYC_I[1] falls.
- Owner 2 STB high, no slave response, TIMEOUT=16 → after 16 STB cycles: ERR_O=0100 and TOUT=1 for exactly one cycle, STB_O=0. A late ACK_S produces no ACK_O. CYC_I[2] drop → IDLE.
- RST_N pulsed low mid-OWN without a clock edge → GNT_V, CYC_O and BUSY go 0 immediately. After release with CYC_I=1111 → GNT=0.
- ACK_S/ERR_S/RTY_S driven while STB_O=0 (IDLE and OWN with the strobe low) → ACK_O, ERR_O and RTY_O stay 0, and the watchdog stays 0.
